// File: rtl/pdm_tx_modulator.sv
// -----------------------------------------------------------------------------
// pdm_tx_modulator
//
// Transmit-side PDM modulator. Signed PCM samples are written into a small
// FIFO; one sample is consumed per frame of OSR PDM bits and converted to a
// 1-bit pulse-density stream by a sigma-delta modulator clocked by a divided
// bit clock.
//
// Build option:
//   PDM_ORDER2_EN  defined   -> second-order modulator (two saturating
//                               integrators of DATA_W+4 bits)
//                  undefined -> first-order modulator (one DATA_W+2 bit
//                               integrator, no saturation needed)
//
// Ports:
//   clk       system clock
//   reset     synchronous, active-low reset
//   write     one-cycle strobe, x_i valid
//   x_i       signed PCM sample
//   full      FIFO holds FIFO_DEPTH samples (registered)
//   sclk      PDM bit clock, high while divider < DIV/2
//   dat_o     PDM data bit, changes together with the rising edge of sclk
//   underrun  one-cycle pulse: frame boundary reached with the FIFO empty
//   overflow  sticky: a write was dropped because the FIFO was full
// -----------------------------------------------------------------------------
module pdm_tx_modulator #(
    parameter int DATA_W     = 16,
    parameter int DIV        = 25,
    parameter int OSR        = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     write,
    input  logic signed [DATA_W-1:0] x_i,
    output logic                     full,
    output logic                     sclk,
    output logic                     dat_o,
    output logic                     underrun,
    output logic                     overflow
);

    localparam int DIV_W = $clog2(DIV);
    localparam int BIT_W = $clog2(OSR);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DIV_W-1:0]         div_cnt, div_next;
    logic [BIT_W-1:0]         bit_cnt;
    logic [PTR_W-1:0]         rd_ptr, wr_ptr;
    logic [CNT_W-1:0]         count, count_next;
    logic signed [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic signed [DATA_W-1:0] cur;

    logic tick, frame_end, fifo_empty, fifo_full_now;
    logic pop, push, drop;
    logic dat_next;

    // ------------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves a signal unassigned, which would infer a latch.
        tick          = (div_cnt == DIV_W'(DIV - 1));
        frame_end     = tick && (bit_cnt == BIT_W'(OSR - 1));
        fifo_empty    = (count == '0);
        fifo_full_now = (count == CNT_W'(FIFO_DEPTH));
        pop           = frame_end && !fifo_empty;
        // A pop in the same cycle frees a slot, so a write into a full FIFO
        // still lands when the frame boundary coincides with it.
        push          = write && (!fifo_full_now || pop);
        drop          = write && fifo_full_now && !pop;
        div_next      = tick ? '0 : div_cnt + 1'b1;

        count_next = count;
        if (push && !pop)
            count_next = count + 1'b1;
        else if (pop && !push)
            count_next = count - 1'b1;
    end

    // ------------------------------------------------------------------------
    // Divider, bit counter, FIFO pointers, status flags
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, independent of statement order.
        if (!reset) begin
            div_cnt  <= '0;
            bit_cnt  <= '0;
            sclk     <= 1'b0;
            underrun <= 1'b0;
            overflow <= 1'b0;
            full     <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            cur      <= '0;
        end else begin
            div_cnt  <= div_next;
            // Registered from the next divider value so sclk rises in the
            // same cycle the freshly modulated bit appears on dat_o.
            sclk     <= (div_next < DIV_W'(DIV / 2));
            underrun <= frame_end && fifo_empty;
            if (tick)
                bit_cnt <= frame_end ? '0 : bit_cnt + 1'b1;
            if (pop) begin
                cur    <= fifo_mem[rd_ptr];
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (drop)
                overflow <= 1'b1;
            count <= count_next;
            full  <= (count_next == CNT_W'(FIFO_DEPTH));
        end
    end

    // NOTE: sample storage is not reset; validity is tracked by count and the
    // pointers, so clearing the array would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= x_i;
    end

    // ------------------------------------------------------------------------
    // Sigma-delta modulator
    // ------------------------------------------------------------------------
`ifdef PDM_ORDER2_EN
    localparam int IW = DATA_W + 4;
    localparam logic signed [IW-1:0] FB_MAG  = IW'(1) <<< (DATA_W - 1);
    localparam logic signed [IW-1:0] SAT_MAX = (IW'(1) <<< (DATA_W + 2)) - IW'(1);

    logic signed [IW-1:0] integ1, integ2, integ1_next, integ2_next, fb;
    logic signed [IW:0]   sum1, sum2;

    function automatic logic signed [IW-1:0] saturate(input logic signed [IW:0] v);
        if (v > (IW + 1)'(SAT_MAX))
            return SAT_MAX;
        else if (v < -((IW + 1)'(SAT_MAX)))
            return -SAT_MAX;
        else
            return v[IW-1:0];
    endfunction

    always_comb begin
        fb          = dat_o ? FB_MAG : -FB_MAG;
        // One guard bit keeps each sum exact before it is clamped.
        sum1        = (IW + 1)'(integ1) + (IW + 1)'(cur) - (IW + 1)'(fb);
        integ1_next = saturate(sum1);
        sum2        = (IW + 1)'(integ2) + (IW + 1)'(integ1_next) - (IW + 1)'(fb);
        integ2_next = saturate(sum2);
        dat_next    = ~integ2_next[IW-1];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            integ1 <= '0;
            integ2 <= '0;
            dat_o  <= 1'b0;
        end else if (tick) begin
            integ1 <= integ1_next;
            integ2 <= integ2_next;
            dat_o  <= dat_next;
        end
    end
`else
    localparam int IW = DATA_W + 2;
    localparam logic signed [IW-1:0] FB_MAG = IW'(1) <<< (DATA_W - 1);

    logic signed [IW-1:0] integ, integ_next, fb;

    always_comb begin
        fb         = dat_o ? FB_MAG : -FB_MAG;
        // |integ| stays within 2^DATA_W, so two extra bits never overflow.
        integ_next = integ + IW'(cur) - fb;
        dat_next   = ~integ_next[IW-1];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            integ <= '0;
            dat_o <= 1'b0;
        end else if (tick) begin
            integ <= integ_next;
            dat_o <= dat_next;
        end
    end
`endif

endmodule

// File: tb/tb_pdm_tx_modulator.sv
// -----------------------------------------------------------------------------
// tb_pdm_tx_modulator
//
// Directed bench for pdm_tx_modulator. A cycle-level reference model built
// from plain arithmetic (cycle index since reset, a sample queue and an
// integer integrator) predicts all outputs; one process compares them on every
// falling clk edge. Directed sequences add hand-computed expectations for
// reset values, sclk shape, underrun timing, FIFO full/overflow and per-frame
// ones densities.
// -----------------------------------------------------------------------------
module tb_pdm_tx_modulator;

    localparam int DATA_W = 16;
    localparam int DIV    = 25;
    localparam int OSR    = 64;
    localparam int DEPTH  = 4;
    localparam int FRAME  = DIV * OSR;
`ifdef PDM_ORDER2_EN
    localparam int SLACK = 2;
`else
    localparam int SLACK = 0;
`endif

    logic                     clk = 1'b0;
    logic                     reset = 1'b0;
    logic                     write = 1'b0;
    logic signed [DATA_W-1:0] x_i = '0;
    logic                     full, sclk, dat_o, underrun, overflow;

    pdm_tx_modulator #(
        .DATA_W    (DATA_W),
        .DIV       (DIV),
        .OSR       (OSR),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .write   (write),
        .x_i     (x_i),
        .full    (full),
        .sclk    (sclk),
        .dat_o   (dat_o),
        .underrun(underrun),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d (t=%0t)", name, act, lo, hi, $time);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out (t=%0t)", name, $time);
    endtask

    // ------------------------------------------------------------------------
    // Reference model: m_phase is the number of clk edges since reset.
    // ------------------------------------------------------------------------
    bit     m_valid = 1'b0;
    int     m_phase;
    int     m_q[$];
    longint m_cur, m_i1, m_i2;
    bit     m_dat, m_sclk, m_full, m_und, m_ovf;

    function automatic longint sat(input longint v);
        longint lim = (longint'(1) <<< (DATA_W + 2)) - 1;
        if (v > lim) return lim;
        if (v < -lim) return -lim;
        return v;
    endfunction

    task automatic model_step();
        bit     tick, fend, pop;
        int     sz;
        longint fb;
        if (!reset) begin
            m_phase = 0;
            m_q.delete();
            m_cur = 0; m_i1 = 0; m_i2 = 0;
            m_dat = 0; m_sclk = 0; m_full = 0; m_und = 0; m_ovf = 0;
            m_valid = 1'b1;
            return;
        end
        if (!m_valid) return;
        tick = (m_phase % DIV) == DIV - 1;
        fend = tick && ((m_phase / DIV) % OSR) == OSR - 1;
        sz   = m_q.size();
        if (tick) begin
            fb = m_dat ? 32768 : -32768;
`ifdef PDM_ORDER2_EN
            m_i1  = sat(m_i1 + m_cur - fb);
            m_i2  = sat(m_i2 + m_i1 - fb);
            m_dat = (m_i2 >= 0);
`else
            m_i1  = m_i1 + m_cur - fb;
            m_dat = (m_i1 >= 0);
`endif
        end
        m_und = fend && (sz == 0);
        pop   = fend && (sz > 0);
        if (pop) m_cur = m_q.pop_front();
        if (write) begin
            if (sz < DEPTH || pop) m_q.push_back(int'(x_i));
            else m_ovf = 1'b1;
        end
        m_phase++;
        m_sclk = (m_phase % DIV) < DIV / 2;
        m_full = (m_q.size() == DEPTH);
    endtask

    always @(posedge clk) model_step();

    always @(negedge clk) begin
        if (m_valid)
            check("cycle {sclk,dat_o,full,underrun,overflow}",
                  {27'd0, sclk, dat_o, full, underrun, overflow},
                  {27'd0, m_sclk, m_dat, m_full, m_und, m_ovf});
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers (all drive on falling clk edges)
    // ------------------------------------------------------------------------
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        write = 1'b0;
        @(negedge clk);
        check("reset sclk", sclk, 0);
        check("reset dat_o", dat_o, 0);
        check("reset full", full, 0);
        check("reset underrun", underrun, 0);
        check("reset overflow", overflow, 0);
        reset = 1'b1;
    endtask

    task automatic wait_phase(input int target);
        int guard = 0;
        while (m_phase < target && guard < 4 * FRAME) begin
            @(negedge clk);
            guard++;
        end
        if (m_phase != target) fail_timeout("wait_phase");
    endtask

    task automatic write_sample(input int v);
        write = 1'b1;
        x_i   = DATA_W'(v);
        @(negedge clk);
        write = 1'b0;
    endtask

    // Counts ones over OSR bits, sampling dat_o on each sclk falling edge.
    task automatic measure_frame(output int ones);
        logic prev;
        int   got, guard;
        prev = sclk; got = 0; guard = 0; ones = 0;
        while (got < OSR && guard < FRAME + 2 * DIV) begin
            @(negedge clk);
            guard++;
            if (prev && !sclk) begin
                ones += int'(dat_o);
                got++;
            end
            prev = sclk;
        end
        if (got < OSR) fail_timeout("measure_frame");
    endtask

    int ones, hi, lo, guard;
    int ovf_samples[5] = '{32767, -32768, 32767, -32768, 0};

    initial begin
        // ---- Idle: sclk shape, underrun cadence, zero-input density ----
        do_reset();
        wait_phase(DIV);
        hi = 0; lo = 0;
        for (int k = 0; k < DIV; k++) begin
            if (sclk) hi++; else lo++;
            @(negedge clk);
        end
        check("sclk high cycles", hi, 12);
        check("sclk low cycles", lo, 13);
        check("sclk rises again after 25", sclk, 1);
        guard = 0;
        while (!underrun && guard < 2 * FRAME) begin
            @(negedge clk);
            guard++;
        end
        check("first underrun cycle", m_phase, FRAME);
        measure_frame(ones);
        check_range("idle density", ones, 31 - SLACK, 33 + SLACK);
        wait_phase(2 * FRAME);
        check("idle second underrun", underrun, 1);

        // ---- Full-scale positive ----
        do_reset();
        wait_phase(5);
        write_sample(32767);
        wait_phase(FRAME);
        measure_frame(ones);
        check_range("+FS first frame", ones, 63 - SLACK, 64);
        wait_phase(2 * FRAME);
        check("+FS underrun after drain", underrun, 1);
        measure_frame(ones);
        check_range("+FS held frame", ones, 63 - SLACK, 64);

        // ---- Full-scale negative ----
        do_reset();
        wait_phase(5);
        write_sample(-32768);
        wait_phase(FRAME);
        measure_frame(ones);
        check_range("-FS first frame", ones, 0, 1 + SLACK);
        wait_phase(2 * FRAME);
        measure_frame(ones);
        check_range("-FS held frame", ones, 0, SLACK);

        // ---- Half-scale positive ----
        do_reset();
        wait_phase(5);
        write_sample(16384);
        wait_phase(2 * FRAME);
        measure_frame(ones);
        check_range("16384 frame 2", ones, 47 - SLACK, 49 + SLACK);
        wait_phase(3 * FRAME);
        measure_frame(ones);
        check_range("16384 frame 3", ones, 47 - SLACK, 49 + SLACK);

        // ---- Back-to-back writes: full, drop, overflow, pop order ----
        do_reset();
        for (int i = 0; i < 5; i++) begin
            write = 1'b1;
            x_i   = DATA_W'(ovf_samples[i]);
            @(negedge clk);
            if (i == 2) check("full after 3 writes", full, 0);
            if (i == 3) check("full after 4 writes", full, 1);
        end
        write = 1'b0;
        check("overflow after 5th write", overflow, 1);
        check("full holds after drop", full, 1);
        wait_phase(FRAME);
        measure_frame(ones);
        check_range("pop1 +FS", ones, 62 - SLACK, 64);
        wait_phase(2 * FRAME);
        measure_frame(ones);
        check_range("pop2 -FS", ones, 0, 1 + SLACK);
        wait_phase(3 * FRAME);
        measure_frame(ones);
        check_range("pop3 +FS", ones, 62 - SLACK, 64);
        wait_phase(4 * FRAME);
        measure_frame(ones);
        check_range("pop4 -FS", ones, 0, 1 + SLACK);
        wait_phase(5 * FRAME);
        check("underrun after 4 pops", underrun, 1);
        check("overflow sticky", overflow, 1);
        measure_frame(ones);
        check_range("dropped sample never played", ones, 0, SLACK);

        // ---- Reset mid-frame with FIFO full and overflow set ----
        do_reset();
        for (int i = 0; i < 5; i++) write_sample(16384);
        wait_phase(1005);
        check("pre-reset full", full, 1);
        check("pre-reset overflow", overflow, 1);
        check("pre-reset sclk", sclk, 1);
        check("pre-reset dat_o", dat_o, 1);
        do_reset();
        wait_phase(FRAME);
        check("post-reset underrun", underrun, 1);
        measure_frame(ones);
        check_range("post-reset density", ones, 31 - SLACK, 33 + SLACK);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
